// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter.
package mem_arb_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef logic port_id_t;

  localparam port_id_t PORT_FETCH = 1'b0;
  localparam port_id_t PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Circular DEPTH x 1-bit queue recording which port owns each outstanding cache request.
module mem_arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  port_id_t         din,
  output port_id_t         dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  port_id_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single cache port with in-order response routing.
// Optional MEM_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_op,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_op,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_op,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  port_id_t         win, head;
  logic             can_push, req_fire, rsp_fire;
  logic             q_full, q_empty;
  logic [CNT_W-1:0] unused_count;
  logic             err_q;

`ifdef MEM_ARB_RR_EN
  port_id_t rr_q;

  always_comb begin
    win = p0_valid ? PORT_FETCH : PORT_DATA;
    if (p0_valid && p1_valid) win = rr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= PORT_FETCH;
    end else if (req_fire) begin
      rr_q <= ~win;
    end
  end
`else
  always_comb begin
    win = p0_valid ? PORT_FETCH : PORT_DATA;
  end
`endif

  // A pop in the same cycle frees the slot a new grant needs.
  assign can_push  = ~q_full | rsp_fire;
  // Outputs are forced idle while reset is held, independent of requester inputs.
  assign mem_valid = ~reset & (p0_valid | p1_valid) & can_push;
  assign req_fire  = mem_valid & mem_ready;
  assign p0_ready  = req_fire & (win == PORT_FETCH);
  assign p1_ready  = req_fire & (win == PORT_DATA);

  assign mem_addr  = (win == PORT_DATA) ? p1_addr  : p0_addr;
  assign mem_op    = (win == PORT_DATA) ? p1_op    : p0_op;
  assign mem_wdata = (win == PORT_DATA) ? p1_wdata : p0_wdata;

  assign mem_rready   = ~q_empty & ((head == PORT_DATA) ? p1_rsp_ready : p0_rsp_ready);
  assign rsp_fire     = mem_rvalid & mem_rready;
  assign p0_rsp_valid = mem_rvalid & ~q_empty & (head == PORT_FETCH);
  assign p1_rsp_valid = mem_rvalid & ~q_empty & (head == PORT_DATA);
  assign p0_rsp_data  = mem_rdata;
  assign p1_rsp_data  = mem_rdata;

  mem_arb_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_fire),
    .din   (win),
    .dout  (head),
    .count (unused_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (mem_rvalid && q_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (DEPTH=2); expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_ready, p0_op, p0_rsp_valid, p0_rsp_ready;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_data;
  logic        p1_valid, p1_ready, p1_op, p1_rsp_valid, p1_rsp_ready;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_data;
  logic        mem_valid, mem_ready, mem_op, mem_rvalid, mem_rready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p0_valid     (p0_valid),
    .p0_ready     (p0_ready),
    .p0_addr      (p0_addr),
    .p0_op        (p0_op),
    .p0_wdata     (p0_wdata),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p0_rsp_data  (p0_rsp_data),
    .p1_valid     (p1_valid),
    .p1_ready     (p1_ready),
    .p1_addr      (p1_addr),
    .p1_op        (p1_op),
    .p1_wdata     (p1_wdata),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .p1_rsp_data  (p1_rsp_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_op       (mem_op),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rready   (mem_rready),
    .mem_rdata    (mem_rdata),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_addr = '0; p0_op = OP_READ; p0_wdata = '0; p0_rsp_ready = 0;
    p1_valid = 0; p1_addr = '0; p1_op = OP_READ; p1_wdata = '0; p1_rsp_ready = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  logic exp_win;

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_p0_ready", 32'(p0_ready), 0);
    check("rst_p1_ready", 32'(p1_ready), 0);
    check("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    check("rst_mem_rready", 32'(mem_rready), 0);
    check("rst_err", 32'(err), 0);
    step();
    reset = 1'b0;

    // 1: lone p0 read, response next cycle
    p0_valid = 1; p0_addr = 32'h10; mem_ready = 1;
    #3;
    check("t1_mem_valid", 32'(mem_valid), 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_op", 32'(mem_op), 0);
    check("t1_p0_ready", 32'(p0_ready), 1);
    check("t1_p1_ready", 32'(p1_ready), 0);
    step();
    p0_valid = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; p0_rsp_ready = 1;
    #3;
    check("t1_p0_rsp_valid", 32'(p0_rsp_valid), 1);
    check("t1_p1_rsp_valid", 32'(p1_rsp_valid), 0);
    check("t1_p0_rsp_data", p0_rsp_data, 32'h1234_5678);
    check("t1_mem_rready", 32'(mem_rready), 1);
    step();
    mem_rvalid = 0;
    #3;
    check("t1_drained", 32'(p0_rsp_valid), 0);

    // 2: both ports valid every cycle, responses popped each cycle after the first
    idle_inputs();
    pulse_reset();
    step();
    p0_valid = 1; p0_addr = 32'h100; p1_valid = 1; p1_addr = 32'h200;
    mem_ready = 1; p0_rsp_ready = 1; p1_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i > 0);
`ifdef MEM_ARB_RR_EN
      exp_win = i[0];
`else
      exp_win = 1'b0;
`endif
      #3;
      check($sformatf("t2_p0_ready_%0d", i), 32'(p0_ready), 32'(!exp_win));
      check($sformatf("t2_p1_ready_%0d", i), 32'(p1_ready), 32'(exp_win));
      check($sformatf("t2_addr_%0d", i), mem_addr, exp_win ? 32'h200 : 32'h100);
      step();
    end
    p0_valid = 0; p1_valid = 0; mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    #3;
    check("t2_err", 32'(err), 0);

    // 3: fill both queue slots with responses blocked; third request stalls until a pop
    idle_inputs();
    pulse_reset();
    step();
    p0_valid = 1; p0_addr = 32'h20; mem_ready = 1;
    #3; check("t3_req0_ready", 32'(p0_ready), 1);
    step();
    p0_addr = 32'h24;
    #3; check("t3_req1_ready", 32'(p0_ready), 1);
    step();
    p0_addr = 32'h28;
    #3;
    check("t3_full_ready", 32'(p0_ready), 0);
    check("t3_full_mem_valid", 32'(mem_valid), 0);
    step();
    mem_rvalid = 1; mem_rdata = 32'hA0;
    #3;
    check("t3_blocked_rsp_valid", 32'(p0_rsp_valid), 1);
    check("t3_blocked_rready", 32'(mem_rready), 0);
    check("t3_blocked_ready", 32'(p0_ready), 0);
    step();
    p0_rsp_ready = 1;
    #3;
    check("t3_pop_rready", 32'(mem_rready), 1);
    check("t3_pop_ready", 32'(p0_ready), 1);
    check("t3_pop_addr", mem_addr, 32'h28);
    step();
    p0_valid = 0;
    #3; check("t3_still_full", 32'(p0_rsp_valid), 1);
    step();
    #3; check("t3_last", 32'(p0_rsp_valid), 1);
    step();
    mem_rvalid = 0;
    #3; check("t3_err", 32'(err), 0);

    // 4: p1 write then p0 read; responses return in request order
    idle_inputs();
    mem_ready = 1; p0_rsp_ready = 1; p1_rsp_ready = 1;
    p1_valid = 1; p1_addr = 32'h4; p1_op = OP_WRITE; p1_wdata = 32'hDEAD_BEEF;
    #3;
    check("t4_wr_ready", 32'(p1_ready), 1);
    check("t4_wr_op", 32'(mem_op), 1);
    check("t4_wr_addr", mem_addr, 32'h4);
    check("t4_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    p1_valid = 0; p0_valid = 1; p0_addr = 32'h4; p0_op = OP_READ;
    mem_rvalid = 1; mem_rdata = 32'h0;
    #3;
    check("t4_ack_p1", 32'(p1_rsp_valid), 1);
    check("t4_ack_not_p0", 32'(p0_rsp_valid), 0);
    check("t4_rd_ready", 32'(p0_ready), 1);
    step();
    p0_valid = 0; mem_rdata = 32'hDEAD_BEEF;
    #3;
    check("t4_rd_p0", 32'(p0_rsp_valid), 1);
    check("t4_rd_not_p1", 32'(p1_rsp_valid), 0);
    check("t4_rd_data", p0_rsp_data, 32'hDEAD_BEEF);
    step();
    mem_rvalid = 0;
    #3; check("t4_err", 32'(err), 0);

    // 5: stray response with an empty queue sets the sticky error
    idle_inputs();
    p0_rsp_ready = 1; p1_rsp_ready = 1; mem_rvalid = 1;
    #3;
    check("t5_rready", 32'(mem_rready), 0);
    check("t5_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    step();
    mem_rvalid = 0;
    #3; check("t5_err_set", 32'(err), 1);
    step();
    step();
    check("t5_err_sticky", 32'(err), 1);

    // 6: reset with two requests outstanding clears everything asynchronously
    idle_inputs();
    pulse_reset();
    step();
    p0_valid = 1; mem_ready = 1;
    step();
    step();
    mem_rvalid = 1; p0_rsp_ready = 1;
    #1;
    check("t6_pre_rsp_valid", 32'(p0_rsp_valid), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_mem_valid", 32'(mem_valid), 0);
    check("t6_rst_p0_ready", 32'(p0_ready), 0);
    check("t6_rst_rsp_valid", 32'(p0_rsp_valid), 0);
    check("t6_rst_rready", 32'(mem_rready), 0);
    check("t6_rst_err", 32'(err), 0);
    mem_rvalid = 0;
    #1;
    reset = 1'b0;
    #1;
    check("t6_after_ready", 32'(p0_ready), 1);
    check("t6_after_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
